alu_control_unit_param: RTL and testbench
=========================================

ALU_CONTROL_UNIT_PARAM -- requirements
Module: alu_control_unit_param

Interface
REQ-001 SHALL have parameter WIDTH, 8, operand width; even and at least 4.
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_input, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port BEGIN, input, 1, start request; sampled only in IDLE.
REQ-005 SHALL have port op_code, input, 2, operation select: 00 add, 01 sub, 10 mul (Radix-4 Booth), 11 div (SRT-2).
REQ-006 SHALL have port q_lsb, input, 3, Q[1:0] plus Q[-1].
REQ-007 SHALL have port a_msb, input, 3, A MS bits.
REQ-008 SHALL have port m_msb, input, 1, M MSb.
REQ-009 SHALL have port m_is_zero, input, 1, M equals 0.
REQ-010 SHALL have ports load_a_inbus, load_q_inbus, load_m_inbus, init_a_zero, output, 1 each, register load and initialise strobes.
REQ-011 SHALL have ports load_a_adder, load_qprim_adder, load_q_adder, output, 1 each, adder-result load strobes.
REQ-012 SHALL have ports rshift, lshift, write_qs, q_bit, qprim_bit, output, 1 each, shift control and SRT-2 quotient digit.
REQ-013 SHALL have ports sel_sub, sel_am, sel_2m, sel_qprim_corr, sel_q_minus_qprim, output, 1 each, adder operand selects.
REQ-014 SHALL have ports push_a, push_q, output, 1 each, OUTBUS drive strobes.
REQ-015 SHALL have ports busy, END, div_by_zero, output, 1 each, status.
REQ-016 SHALL have port state_dbg, output, 18, one-hot current state.

Function
REQ-017 SHALL implement a one-hot Moore FSM with 18 states: IDLE LOADA LOADQ LOADM ADDM ADDCORR ADD1QP QMINQP PUSHA PUSHQ RSHIFT RSHIFT2 CNTR LSHIFT CNTL LSH0 RSH0 ERR.
REQ-018 SHALL latch op_code into op_r when leaving IDLE on BEGIN=1; op_code changes mid-operation have no effect.
REQ-019 SHALL keep busy=1 in every state except IDLE; BEGIN is ignored while busy=1.
REQ-020 Add/sub SHALL sequence IDLE->LOADA->LOADM->ADDM->PUSHA->IDLE; sel_sub=op_r[0] in ADDM.
REQ-021 Mul SHALL sequence IDLE->LOADQ (init_a_zero=1)->LOADM.
REQ-022 Mul, from LOADM and CNTR, SHALL go to ADDM if q_lsb is not 000/111, else to RSHIFT.
REQ-023 Mul SHALL sequence ADDM->RSHIFT->RSHIFT2.
REQ-024 Mul, from RSHIFT2, SHALL go to PUSHA when r4_cnt==WIDTH/2-1, else to CNTR (r4_cnt+1); then PUSHA->PUSHQ->IDLE.
REQ-025 In mul ADDM, sel_2m SHALL be 1 iff q_lsb is 011 or 100, and sel_sub SHALL equal q_lsb[2].
REQ-026 Div SHALL sequence IDLE->LOADA->LOADQ->LOADM.
REQ-027 Div, from LOADM, SHALL go to ERR if m_is_zero=1, else to LSH0 while m_msb=0 (lz_cnt+1, lshift=1 per visit), then to LSHIFT.
REQ-028 In LSHIFT: nz = a_msb not in {000,111}; write_qs=1; q_bit=nz&~a_msb[2]; qprim_bit=nz&a_msb[2]; nz and a_msb[2] latched into flag_r and sign_r.
REQ-029 From LSHIFT, nz=1 SHALL go to ADDM (sel_sub=~sign_r); then ADDM and nz=0 LSHIFT share the successor rule in REQ-030.
REQ-030 That successor SHALL be CNTL (srt_cnt+1, then LSHIFT) if srt_cnt<WIDTH-1, else the end phase.
REQ-031 End phase SHALL be ADDCORR->ADD1QP->QMINQP if a_msb[2]=1, else QMINQP directly.
REQ-032 After QMINQP, div SHALL visit RSH0 while lz_cnt>0 (lz_cnt-1, rshift=1), then PUSHQ->PUSHA->IDLE.
REQ-033 ERR SHALL assert div_by_zero=1 and END=1 for exactly one cycle, then return to IDLE.
REQ-034 END SHALL be 1 exactly in the final push state of each operation, or in ERR.
REQ-035 Strobes SHALL be decoded from the current state only: load_* in LOAD*; load_a_adder/sel_am in ADDM/ADDCORR; load_qprim_adder/sel_qprim_corr in ADD1QP; load_q_adder/sel_q_minus_qprim/sel_sub in QMINQP; rshift in RSHIFT/RSHIFT2/RSH0; lshift in LSHIFT/LSH0; push_* in PUSH*.
REQ-036 Counter widths SHALL be $clog2(WIDTH)+1; counters clear on leaving IDLE; no wrap-around reachable.
REQ-037 An all-zero or multi-hot state register SHALL recover to IDLE on the next edge.

Reset
REQ-038 While reset_input=1 at an edge, the FSM SHALL enter IDLE; counters, op_r, flag_r and sign_r SHALL clear; every output except state_dbg[IDLE] SHALL be 0; END SHALL not pulse.
REQ-039 Reset mid-operation SHALL abort with no push or END.

Structure
REQ-040 A shared package alu_cu_pkg SHALL hold state index constants, state count, and OP_ADD/OP_SUB/OP_MUL/OP_DIV.
REQ-041 Counters SHALL use one sub-module, alu_cu_counter (parametrised width, sync clear, inc, dec), instantiated three times.

Verification (WIDTH=8)
REQ-042 op 00, BEGIN pulse -> LOADA, LOADM, ADDM, PUSHA; END=1 in PUSHA, 4 cycles after acceptance.
REQ-043 op 10, q_lsb held 000 -> no ADDM visits; exactly 4 RSHIFT/RSHIFT2 pairs; PUSHA then PUSHQ with END=1.
REQ-044 op 11, m_is_zero=1 -> LOADA, LOADQ, LOADM, ERR with div_by_zero=END=1, then IDLE.
REQ-045 op 11, m_msb=0 for 3 cycles -> 3 LSH0 visits; after QMINQP exactly 3 RSH0 before PUSHQ.
REQ-046 op 11, a_msb=100 at last iteration -> ADDCORR, ADD1QP, QMINQP in order; with a_msb=011 -> QMINQP directly.
REQ-047 reset_input=1 while in CNTR -> IDLE next cycle, all strobes 0; BEGIN pulses while busy=1 cause no restart.

Source files
------------

// File: rtl/alu_cu_pkg.sv
// rtl/alu_cu_pkg.sv - shared state indices, opcodes and one-hot helpers for the ALU control unit
package alu_cu_pkg;

  localparam int N_STATES = 18;

  typedef enum logic [4:0] {
    S_IDLE    = 5'd0,
    S_LOADA   = 5'd1,
    S_LOADQ   = 5'd2,
    S_LOADM   = 5'd3,
    S_ADDM    = 5'd4,
    S_ADDCORR = 5'd5,
    S_ADD1QP  = 5'd6,
    S_QMINQP  = 5'd7,
    S_PUSHA   = 5'd8,
    S_PUSHQ   = 5'd9,
    S_RSHIFT  = 5'd10,
    S_RSHIFT2 = 5'd11,
    S_CNTR    = 5'd12,
    S_LSHIFT  = 5'd13,
    S_CNTL    = 5'd14,
    S_LSH0    = 5'd15,
    S_RSH0    = 5'd16,
    S_ERR     = 5'd17
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  function automatic logic [N_STATES-1:0] onehot(input state_e s);
    onehot = '0;
    onehot[s] = 1'b1;
  endfunction

endpackage

// File: rtl/alu_control_unit_param_if.sv
// rtl/alu_control_unit_param_if.sv - datapath status and control strobe bundle between controller and datapath
interface alu_control_unit_param_if;

  logic        BEGIN;
  logic [1:0]  op_code;
  logic [2:0]  q_lsb;
  logic [2:0]  a_msb;
  logic        m_msb;
  logic        m_is_zero;
  logic        load_a_inbus;
  logic        load_q_inbus;
  logic        load_m_inbus;
  logic        init_a_zero;
  logic        load_a_adder;
  logic        load_qprim_adder;
  logic        load_q_adder;
  logic        rshift;
  logic        lshift;
  logic        write_qs;
  logic        q_bit;
  logic        qprim_bit;
  logic        sel_sub;
  logic        sel_am;
  logic        sel_2m;
  logic        sel_qprim_corr;
  logic        sel_q_minus_qprim;
  logic        push_a;
  logic        push_q;
  logic        busy;
  logic        END;
  logic        div_by_zero;
  logic [17:0] state_dbg;

  modport master (
    output BEGIN, op_code, q_lsb, a_msb, m_msb, m_is_zero,
    input  load_a_inbus, load_q_inbus, load_m_inbus, init_a_zero,
    input  load_a_adder, load_qprim_adder, load_q_adder,
    input  rshift, lshift, write_qs, q_bit, qprim_bit,
    input  sel_sub, sel_am, sel_2m, sel_qprim_corr, sel_q_minus_qprim,
    input  push_a, push_q, busy, END, div_by_zero, state_dbg
  );

  modport slave (
    input  BEGIN, op_code, q_lsb, a_msb, m_msb, m_is_zero,
    output load_a_inbus, load_q_inbus, load_m_inbus, init_a_zero,
    output load_a_adder, load_qprim_adder, load_q_adder,
    output rshift, lshift, write_qs, q_bit, qprim_bit,
    output sel_sub, sel_am, sel_2m, sel_qprim_corr, sel_q_minus_qprim,
    output push_a, push_q, busy, END, div_by_zero, state_dbg
  );

endinterface

// File: rtl/alu_control_unit_param_fsm.sv
// rtl/alu_control_unit_param_fsm.sv - one-hot sequencer for add/sub, Radix-4 Booth multiply and SRT-2 divide
module alu_control_unit_param_fsm
  import alu_cu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                    clk,
  input logic                    reset_input,
  alu_control_unit_param_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [N_STATES-1:0] state, state_next, st;
  logic [1:0]          op_r;
  logic                flag_r, sign_r;
  logic [CW-1:0]       r4_cnt, lz_cnt, srt_cnt;
  logic                valid, accept, nz, booth_add;
  state_e              nxt, booth_next, div_next;

  // Anything other than exactly one hot bit is treated as corrupt and falls back to IDLE.
  assign valid      = (state != '0) && ((state & (state - N_STATES'(1))) == '0);
  assign st         = valid ? state : '0;
  assign accept     = st[S_IDLE] & bus.BEGIN;
  assign nz         = (bus.a_msb != 3'b000) && (bus.a_msb != 3'b111);
  assign booth_add  = (bus.q_lsb != 3'b000) && (bus.q_lsb != 3'b111);
  assign booth_next = booth_add ? S_ADDM : S_RSHIFT;
  assign div_next   = (srt_cnt < CW'(WIDTH - 1)) ? S_CNTL :
                      (bus.a_msb[2] ? S_ADDCORR : S_QMINQP);

  always_ff @(posedge clk) begin
    if (reset_input) begin
      state  <= onehot(S_IDLE);
      op_r   <= '0;
      flag_r <= 1'b0;
      sign_r <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) op_r <= bus.op_code;
      if (st[S_LSHIFT]) begin
        flag_r <= nz;
        sign_r <= bus.a_msb[2];
      end
    end
  end

  always_comb begin
    nxt = S_IDLE;
    case (1'b1)
      st[S_IDLE]:    if (bus.BEGIN) nxt = (bus.op_code == OP_MUL) ? S_LOADQ : S_LOADA;
      st[S_LOADA]:   nxt = (op_r == OP_DIV) ? S_LOADQ : S_LOADM;
      st[S_LOADQ]:   nxt = S_LOADM;
      st[S_LOADM]: begin
        case (op_r)
          OP_MUL:  nxt = booth_next;
          OP_DIV:  nxt = bus.m_is_zero ? S_ERR : (bus.m_msb ? S_LSHIFT : S_LSH0);
          default: nxt = S_ADDM;
        endcase
      end
      st[S_ADDM]: begin
        case (op_r)
          OP_MUL:  nxt = S_RSHIFT;
          OP_DIV:  nxt = div_next;
          default: nxt = S_PUSHA;
        endcase
      end
      st[S_ADDCORR]: nxt = S_ADD1QP;
      st[S_ADD1QP]:  nxt = S_QMINQP;
      st[S_QMINQP]:  nxt = (lz_cnt != '0) ? S_RSH0 : S_PUSHQ;
      st[S_PUSHA]:   nxt = (op_r == OP_MUL) ? S_PUSHQ : S_IDLE;
      st[S_PUSHQ]:   nxt = (op_r == OP_DIV) ? S_PUSHA : S_IDLE;
      st[S_RSHIFT]:  nxt = S_RSHIFT2;
      st[S_RSHIFT2]: nxt = (r4_cnt == CW'(WIDTH / 2 - 1)) ? S_PUSHA : S_CNTR;
      st[S_CNTR]:    nxt = booth_next;
      st[S_LSHIFT]:  nxt = nz ? S_ADDM : div_next;
      st[S_CNTL]:    nxt = S_LSHIFT;
      st[S_LSH0]:    nxt = bus.m_msb ? S_LSHIFT : S_LSH0;
      // lz_cnt still holds the pre-decrement value here, so stop once it reaches 1.
      st[S_RSH0]:    nxt = (lz_cnt > CW'(1)) ? S_RSH0 : S_PUSHQ;
      st[S_ERR]:     nxt = S_IDLE;
      default:       nxt = S_IDLE;
    endcase
    state_next = onehot(nxt);
  end

  always_comb begin
    bus.load_a_inbus      = st[S_LOADA];
    bus.load_q_inbus      = st[S_LOADQ];
    bus.load_m_inbus      = st[S_LOADM];
    bus.init_a_zero       = st[S_LOADQ] & (op_r == OP_MUL);
    bus.load_a_adder      = st[S_ADDCORR];
    bus.sel_am            = st[S_ADDCORR];
    bus.load_qprim_adder  = st[S_ADD1QP];
    bus.sel_qprim_corr    = st[S_ADD1QP];
    bus.load_q_adder      = st[S_QMINQP];
    bus.sel_q_minus_qprim = st[S_QMINQP];
    bus.sel_sub           = st[S_QMINQP];
    bus.sel_2m            = 1'b0;
    bus.rshift            = st[S_RSHIFT] | st[S_RSHIFT2] | st[S_RSH0];
    bus.lshift            = st[S_LSHIFT] | st[S_LSH0];
    bus.write_qs          = st[S_LSHIFT];
    bus.q_bit             = st[S_LSHIFT] & nz & ~bus.a_msb[2];
    bus.qprim_bit         = st[S_LSHIFT] & nz & bus.a_msb[2];
    bus.push_a            = st[S_PUSHA];
    bus.push_q            = st[S_PUSHQ];
    bus.busy              = ~st[S_IDLE];
    bus.div_by_zero       = st[S_ERR];
    bus.END               = st[S_ERR] | (st[S_PUSHA] & (op_r != OP_MUL)) |
                            (st[S_PUSHQ] & (op_r == OP_MUL));
    bus.state_dbg         = state;
    if (st[S_ADDM]) begin
      bus.sel_am       = 1'b1;
      bus.load_a_adder = (op_r == OP_DIV) ? flag_r : 1'b1;
      case (op_r)
        OP_MUL: begin
          bus.sel_sub = bus.q_lsb[2];
          bus.sel_2m  = (bus.q_lsb == 3'b011) || (bus.q_lsb == 3'b100);
        end
        OP_DIV:  bus.sel_sub = ~sign_r;
        default: bus.sel_sub = op_r[0];
      endcase
    end
  end

  alu_cu_counter #(.W(CW)) u_r4_cnt (
    .clk(clk), .rst(reset_input), .clr(accept),
    .inc(st[S_CNTR]), .dec(1'b0), .count(r4_cnt)
  );

  alu_cu_counter #(.W(CW)) u_lz_cnt (
    .clk(clk), .rst(reset_input), .clr(accept),
    .inc(st[S_LSH0]), .dec(st[S_RSH0]), .count(lz_cnt)
  );

  alu_cu_counter #(.W(CW)) u_srt_cnt (
    .clk(clk), .rst(reset_input), .clr(accept),
    .inc(st[S_CNTL]), .dec(1'b0), .count(srt_cnt)
  );

endmodule

// File: rtl/alu_cu_counter.sv
// rtl/alu_cu_counter.sv - small up/down iteration counter with synchronous clear
module alu_cu_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end else if (dec) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/alu_control_unit_param.sv
// rtl/alu_control_unit_param.sv - ALU control unit top: flat pin view around the bundled sequencer
module alu_control_unit_param #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset_input,
  input  logic        BEGIN,
  input  logic [1:0]  op_code,
  input  logic [2:0]  q_lsb,
  input  logic [2:0]  a_msb,
  input  logic        m_msb,
  input  logic        m_is_zero,
  output logic        load_a_inbus,
  output logic        load_q_inbus,
  output logic        load_m_inbus,
  output logic        init_a_zero,
  output logic        load_a_adder,
  output logic        load_qprim_adder,
  output logic        load_q_adder,
  output logic        rshift,
  output logic        lshift,
  output logic        write_qs,
  output logic        q_bit,
  output logic        qprim_bit,
  output logic        sel_sub,
  output logic        sel_am,
  output logic        sel_2m,
  output logic        sel_qprim_corr,
  output logic        sel_q_minus_qprim,
  output logic        push_a,
  output logic        push_q,
  output logic        busy,
  output logic        END,
  output logic        div_by_zero,
  output logic [17:0] state_dbg
);

  alu_control_unit_param_if cu_bus ();

  assign cu_bus.BEGIN     = BEGIN;
  assign cu_bus.op_code   = op_code;
  assign cu_bus.q_lsb     = q_lsb;
  assign cu_bus.a_msb     = a_msb;
  assign cu_bus.m_msb     = m_msb;
  assign cu_bus.m_is_zero = m_is_zero;

  assign load_a_inbus      = cu_bus.load_a_inbus;
  assign load_q_inbus      = cu_bus.load_q_inbus;
  assign load_m_inbus      = cu_bus.load_m_inbus;
  assign init_a_zero       = cu_bus.init_a_zero;
  assign load_a_adder      = cu_bus.load_a_adder;
  assign load_qprim_adder  = cu_bus.load_qprim_adder;
  assign load_q_adder      = cu_bus.load_q_adder;
  assign rshift            = cu_bus.rshift;
  assign lshift            = cu_bus.lshift;
  assign write_qs          = cu_bus.write_qs;
  assign q_bit             = cu_bus.q_bit;
  assign qprim_bit         = cu_bus.qprim_bit;
  assign sel_sub           = cu_bus.sel_sub;
  assign sel_am            = cu_bus.sel_am;
  assign sel_2m            = cu_bus.sel_2m;
  assign sel_qprim_corr    = cu_bus.sel_qprim_corr;
  assign sel_q_minus_qprim = cu_bus.sel_q_minus_qprim;
  assign push_a            = cu_bus.push_a;
  assign push_q            = cu_bus.push_q;
  assign busy              = cu_bus.busy;
  assign END               = cu_bus.END;
  assign div_by_zero       = cu_bus.div_by_zero;
  assign state_dbg         = cu_bus.state_dbg;

  alu_control_unit_param_fsm #(.WIDTH(WIDTH)) u_fsm (
    .clk         (clk),
    .reset_input (reset_input),
    .bus         (cu_bus)
  );

endmodule

// File: tb/tb_alu_control_unit_param.sv
// tb/tb_alu_control_unit_param.sv - directed state-sequence bench for alu_control_unit_param (WIDTH=8)
module tb_alu_control_unit_param;

  localparam int ST_IDLE = 0, ST_LOADA = 1, ST_LOADQ = 2, ST_LOADM = 3, ST_ADDM = 4;
  localparam int ST_ADDCORR = 5, ST_ADD1QP = 6, ST_QMINQP = 7, ST_PUSHA = 8, ST_PUSHQ = 9;
  localparam int ST_RSHIFT = 10, ST_RSHIFT2 = 11, ST_CNTR = 12, ST_LSHIFT = 13, ST_CNTL = 14;
  localparam int ST_LSH0 = 15, ST_RSH0 = 16, ST_ERR = 17;

  logic clk;
  logic reset_input;
  int   errors;
  int   checks;

  alu_control_unit_param_if bus ();

  logic [21:0] strobes;
  assign strobes = {bus.load_a_inbus, bus.load_q_inbus, bus.load_m_inbus, bus.init_a_zero,
                    bus.load_a_adder, bus.load_qprim_adder, bus.load_q_adder, bus.rshift,
                    bus.lshift, bus.write_qs, bus.q_bit, bus.qprim_bit, bus.sel_sub, bus.sel_am,
                    bus.sel_2m, bus.sel_qprim_corr, bus.sel_q_minus_qprim, bus.push_a,
                    bus.push_q, bus.busy, bus.END, bus.div_by_zero};

  alu_control_unit_param #(.WIDTH(8)) dut (
    .clk(clk), .reset_input(reset_input), .BEGIN(bus.BEGIN), .op_code(bus.op_code),
    .q_lsb(bus.q_lsb), .a_msb(bus.a_msb), .m_msb(bus.m_msb), .m_is_zero(bus.m_is_zero),
    .load_a_inbus(bus.load_a_inbus), .load_q_inbus(bus.load_q_inbus),
    .load_m_inbus(bus.load_m_inbus), .init_a_zero(bus.init_a_zero),
    .load_a_adder(bus.load_a_adder), .load_qprim_adder(bus.load_qprim_adder),
    .load_q_adder(bus.load_q_adder), .rshift(bus.rshift), .lshift(bus.lshift),
    .write_qs(bus.write_qs), .q_bit(bus.q_bit), .qprim_bit(bus.qprim_bit),
    .sel_sub(bus.sel_sub), .sel_am(bus.sel_am), .sel_2m(bus.sel_2m),
    .sel_qprim_corr(bus.sel_qprim_corr), .sel_q_minus_qprim(bus.sel_q_minus_qprim),
    .push_a(bus.push_a), .push_q(bus.push_q), .busy(bus.busy), .END(bus.END),
    .div_by_zero(bus.div_by_zero), .state_dbg(bus.state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_input = 1'b1;
    bus.BEGIN = 1'b1;
    bus.op_code = 2'b10;
    tick();
    tick();
    checks++;
    if (bus.state_dbg !== 18'h00001) begin
      errors++; $display("FAIL reset_state got=%h want=%h", bus.state_dbg, 18'h00001);
    end
    checks++;
    if (strobes !== 22'h0) begin
      errors++; $display("FAIL reset_strobes got=%h want=0", strobes);
    end
    bus.BEGIN = 1'b0;
    reset_input = 1'b0;
    tick();
    checks++;
    if (bus.state_dbg !== 18'h00001 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_release got=%h busy=%b want=00001 busy=0", bus.state_dbg, bus.busy);
    end
  endtask

  task automatic test_addsub(input logic [1:0] op, input logic exp_sub, input bit hold_begin);
    int          exp_q[$];
    logic [17:0] ev;
    exp_q = '{ST_LOADA, ST_LOADM, ST_ADDM, ST_PUSHA, ST_IDLE, ST_IDLE};
    bus.op_code = op;
    bus.BEGIN = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      ev = '0; ev[exp_q[i]] = 1'b1;
      checks++;
      if (bus.state_dbg !== ev) begin
        errors++; $display("FAIL addsub_seq op=%b step=%0d got=%h want=%h", op, i, bus.state_dbg, ev);
      end
      if (exp_q[i] == ST_ADDM) begin
        checks++;
        if (bus.sel_sub !== exp_sub || bus.load_a_adder !== 1'b1 || bus.sel_am !== 1'b1 || bus.sel_2m !== 1'b0) begin
          errors++; $display("FAIL addsub_addm op=%b sel_sub=%b want=%b", op, bus.sel_sub, exp_sub);
        end
      end
      if (exp_q[i] == ST_PUSHA) begin
        checks++;
        if (bus.END !== 1'b1 || bus.push_a !== 1'b1 || bus.push_q !== 1'b0) begin
          errors++; $display("FAIL addsub_end op=%b END=%b push_a=%b want 1 1", op, bus.END, bus.push_a);
        end
        bus.BEGIN = 1'b0;
      end
      if (i == 0 && !hold_begin) bus.BEGIN = 1'b0;
      if (i == 0) bus.op_code = ~op;
    end
  endtask

  task automatic test_mul_zero();
    int          exp_q[$];
    logic [17:0] ev;
    int          n_addm, n_rsh;
    exp_q = '{ST_LOADQ, ST_LOADM, ST_RSHIFT, ST_RSHIFT2, ST_CNTR, ST_RSHIFT, ST_RSHIFT2, ST_CNTR,
              ST_RSHIFT, ST_RSHIFT2, ST_CNTR, ST_RSHIFT, ST_RSHIFT2, ST_PUSHA, ST_PUSHQ, ST_IDLE};
    n_addm = 0; n_rsh = 0;
    bus.op_code = 2'b10;
    bus.q_lsb = 3'b000;
    bus.BEGIN = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      bus.BEGIN = 1'b0;
      ev = '0; ev[exp_q[i]] = 1'b1;
      n_addm += int'(bus.state_dbg[ST_ADDM]);
      n_rsh += int'(bus.state_dbg[ST_RSHIFT]);
      checks++;
      if (bus.state_dbg !== ev) begin
        errors++; $display("FAIL mul_seq step=%0d got=%h want=%h", i, bus.state_dbg, ev);
      end
      if (exp_q[i] == ST_LOADQ) begin
        checks++;
        if (bus.init_a_zero !== 1'b1 || bus.load_q_inbus !== 1'b1) begin
          errors++; $display("FAIL mul_init_a_zero got=%b want=1", bus.init_a_zero);
        end
      end
      if (exp_q[i] == ST_PUSHA || exp_q[i] == ST_PUSHQ) begin
        checks++;
        if (bus.END !== (exp_q[i] == ST_PUSHQ)) begin
          errors++; $display("FAIL mul_end step=%0d END=%b want=%b", i, bus.END, exp_q[i] == ST_PUSHQ);
        end
      end
    end
    checks++;
    if (n_addm != 0 || n_rsh != 4) begin
      errors++; $display("FAIL mul_counts addm=%0d rshift=%0d want 0 and 4", n_addm, n_rsh);
    end
  endtask

  task automatic test_mul_booth();
    logic [2:0]  pat     [4] = '{3'b011, 3'b100, 3'b111, 3'b001};
    bit          exp_add [4] = '{1, 1, 0, 1};
    logic        exp_2m  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic        exp_sb  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int          exp_q[$];
    logic [17:0] ev;
    int          k;
    exp_q = '{ST_LOADQ, ST_LOADM};
    for (int j = 0; j < 4; j++) begin
      if (exp_add[j]) exp_q.push_back(ST_ADDM);
      exp_q.push_back(ST_RSHIFT);
      exp_q.push_back(ST_RSHIFT2);
      exp_q.push_back(j < 3 ? ST_CNTR : ST_PUSHA);
    end
    exp_q.push_back(ST_PUSHQ);
    exp_q.push_back(ST_IDLE);
    k = 0;
    bus.op_code = 2'b10;
    bus.q_lsb = pat[0];
    bus.BEGIN = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      bus.BEGIN = 1'b0;
      ev = '0; ev[exp_q[i]] = 1'b1;
      checks++;
      if (bus.state_dbg !== ev) begin
        errors++; $display("FAIL booth_seq step=%0d got=%h want=%h", i, bus.state_dbg, ev);
      end
      if (exp_q[i] == ST_ADDM) begin
        checks++;
        if (bus.sel_2m !== exp_2m[k] || bus.sel_sub !== exp_sb[k]) begin
          errors++; $display("FAIL booth_sel q_lsb=%b sel_2m=%b sel_sub=%b want %b %b",
                             pat[k], bus.sel_2m, bus.sel_sub, exp_2m[k], exp_sb[k]);
        end
      end
      if (exp_q[i] == ST_RSHIFT2 && k < 3) begin
        k++;
        bus.q_lsb = pat[k];
      end
    end
    bus.q_lsb = 3'b000;
  endtask

  task automatic test_div_zero();
    int          exp_q[$];
    logic [17:0] ev;
    exp_q = '{ST_LOADA, ST_LOADQ, ST_LOADM, ST_ERR, ST_IDLE};
    bus.op_code = 2'b11;
    bus.m_is_zero = 1'b1;
    bus.BEGIN = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      bus.BEGIN = 1'b0;
      ev = '0; ev[exp_q[i]] = 1'b1;
      checks++;
      if (bus.state_dbg !== ev) begin
        errors++; $display("FAIL divz_seq step=%0d got=%h want=%h", i, bus.state_dbg, ev);
      end
      if (exp_q[i] == ST_LOADQ) begin
        checks++;
        if (bus.init_a_zero !== 1'b0) begin
          errors++; $display("FAIL divz_init_a_zero got=%b want=0", bus.init_a_zero);
        end
      end
      checks++;
      if (bus.div_by_zero !== (exp_q[i] == ST_ERR) || bus.END !== (exp_q[i] == ST_ERR)) begin
        errors++; $display("FAIL divz_flags step=%0d dbz=%b END=%b want=%b", i, bus.div_by_zero,
                           bus.END, exp_q[i] == ST_ERR);
      end
    end
    bus.m_is_zero = 1'b0;
  endtask

  task automatic test_div_lz();
    int          exp_q[$];
    logic [17:0] ev;
    int          n_lsh0, n_rsh0;
    exp_q = '{ST_LOADA, ST_LOADQ, ST_LOADM, ST_LSH0, ST_LSH0, ST_LSH0, ST_LSHIFT};
    for (int j = 0; j < 7; j++) begin
      exp_q.push_back(ST_CNTL);
      exp_q.push_back(ST_LSHIFT);
    end
    exp_q.push_back(ST_QMINQP);
    for (int j = 0; j < 3; j++) exp_q.push_back(ST_RSH0);
    exp_q.push_back(ST_PUSHQ);
    exp_q.push_back(ST_PUSHA);
    exp_q.push_back(ST_IDLE);
    n_lsh0 = 0; n_rsh0 = 0;
    bus.op_code = 2'b11;
    bus.m_msb = 1'b0;
    bus.a_msb = 3'b000;
    bus.BEGIN = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      bus.BEGIN = 1'b0;
      ev = '0; ev[exp_q[i]] = 1'b1;
      n_lsh0 += int'(bus.state_dbg[ST_LSH0] & bus.lshift);
      n_rsh0 += int'(bus.state_dbg[ST_RSH0] & bus.rshift);
      checks++;
      if (bus.state_dbg !== ev) begin
        errors++; $display("FAIL divlz_seq step=%0d got=%h want=%h", i, bus.state_dbg, ev);
      end
      if (exp_q[i] == ST_LSHIFT) begin
        checks++;
        if (bus.write_qs !== 1'b1 || bus.q_bit !== 1'b0 || bus.qprim_bit !== 1'b0) begin
          errors++; $display("FAIL divlz_digit step=%0d wqs=%b q=%b qp=%b want 1 0 0", i,
                             bus.write_qs, bus.q_bit, bus.qprim_bit);
        end
      end
      if (exp_q[i] == ST_PUSHQ || exp_q[i] == ST_PUSHA) begin
        checks++;
        if (bus.END !== (exp_q[i] == ST_PUSHA)) begin
          errors++; $display("FAIL divlz_end step=%0d END=%b want=%b", i, bus.END, exp_q[i] == ST_PUSHA);
        end
      end
      if (i == 5) bus.m_msb = 1'b1;
    end
    checks++;
    if (n_lsh0 != 3 || n_rsh0 != 3) begin
      errors++; $display("FAIL divlz_counts lsh0=%0d rsh0=%0d want 3 and 3", n_lsh0, n_rsh0);
    end
  endtask

  task automatic test_div_end(input logic [2:0] am, input bit corr, input logic exp_q_bit,
                              input logic exp_sub);
    int          exp_q[$];
    logic [17:0] ev;
    exp_q = '{ST_LOADA, ST_LOADQ, ST_LOADM};
    for (int j = 0; j < 8; j++) begin
      exp_q.push_back(ST_LSHIFT);
      exp_q.push_back(ST_ADDM);
      if (j < 7) exp_q.push_back(ST_CNTL);
    end
    if (corr) begin
      exp_q.push_back(ST_ADDCORR);
      exp_q.push_back(ST_ADD1QP);
    end
    exp_q.push_back(ST_QMINQP);
    exp_q.push_back(ST_PUSHQ);
    exp_q.push_back(ST_PUSHA);
    exp_q.push_back(ST_IDLE);
    bus.op_code = 2'b11;
    bus.m_msb = 1'b1;
    bus.a_msb = am;
    bus.BEGIN = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      bus.BEGIN = 1'b0;
      ev = '0; ev[exp_q[i]] = 1'b1;
      checks++;
      if (bus.state_dbg !== ev) begin
        errors++; $display("FAIL divend_seq a_msb=%b step=%0d got=%h want=%h", am, i, bus.state_dbg, ev);
      end
      if (exp_q[i] == ST_LSHIFT) begin
        checks++;
        if (bus.q_bit !== exp_q_bit || bus.qprim_bit !== ~exp_q_bit) begin
          errors++; $display("FAIL divend_digit a_msb=%b q=%b qp=%b want q=%b", am, bus.q_bit,
                             bus.qprim_bit, exp_q_bit);
        end
      end
      if (exp_q[i] == ST_ADDM) begin
        checks++;
        if (bus.sel_sub !== exp_sub || bus.load_a_adder !== 1'b1) begin
          errors++; $display("FAIL divend_addm a_msb=%b sel_sub=%b want=%b", am, bus.sel_sub, exp_sub);
        end
      end
      if (exp_q[i] == ST_ADD1QP) begin
        checks++;
        if (bus.load_qprim_adder !== 1'b1 || bus.sel_qprim_corr !== 1'b1) begin
          errors++; $display("FAIL divend_add1qp got=%b%b want=11", bus.load_qprim_adder, bus.sel_qprim_corr);
        end
      end
      if (exp_q[i] == ST_QMINQP) begin
        checks++;
        if (bus.load_q_adder !== 1'b1 || bus.sel_q_minus_qprim !== 1'b1 || bus.sel_sub !== 1'b1) begin
          errors++; $display("FAIL divend_qminqp got=%b%b%b want=111", bus.load_q_adder,
                             bus.sel_q_minus_qprim, bus.sel_sub);
        end
      end
    end
    bus.a_msb = 3'b000;
  endtask

  task automatic test_reset_mid();
    int          exp_q[$];
    logic [17:0] ev;
    exp_q = '{ST_LOADQ, ST_LOADM, ST_RSHIFT, ST_RSHIFT2, ST_CNTR};
    bus.op_code = 2'b10;
    bus.q_lsb = 3'b000;
    bus.BEGIN = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      bus.BEGIN = 1'b0;
      ev = '0; ev[exp_q[i]] = 1'b1;
      checks++;
      if (bus.state_dbg !== ev) begin
        errors++; $display("FAIL rstmid_seq step=%0d got=%h want=%h", i, bus.state_dbg, ev);
      end
    end
    reset_input = 1'b1;
    tick();
    checks++;
    if (bus.state_dbg !== 18'h00001 || strobes !== 22'h0) begin
      errors++; $display("FAIL rstmid_abort state=%h strobes=%h want 00001 0", bus.state_dbg, strobes);
    end
    reset_input = 1'b0;
    tick();
    checks++;
    if (bus.state_dbg !== 18'h00001 || bus.END !== 1'b0) begin
      errors++; $display("FAIL rstmid_after state=%h END=%b want 00001 0", bus.state_dbg, bus.END);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset_input = 1'b1;
    bus.BEGIN = 1'b0;
    bus.op_code = 2'b00;
    bus.q_lsb = 3'b000;
    bus.a_msb = 3'b000;
    bus.m_msb = 1'b0;
    bus.m_is_zero = 1'b0;
    test_reset();
    test_addsub(2'b00, 1'b0, 1'b0);
    test_addsub(2'b01, 1'b1, 1'b0);
    test_addsub(2'b00, 1'b0, 1'b1);
    test_mul_zero();
    test_mul_booth();
    test_div_zero();
    test_div_lz();
    test_div_end(3'b100, 1'b1, 1'b0, 1'b0);
    test_div_end(3'b011, 1'b0, 1'b1, 1'b1);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
